// File: rtl/seven_segment_to_octal_decoder_pkg.sv
// Shared seven-segment definitions: active-low digit patterns, decode record and
// receive FSM states, used by both the octal encoder and this decoder.
package seven_segment_to_octal_decoder_pkg;

  // Bit 6 = g ... bit 0 = a, active-low (0 lights the segment).
  localparam logic [6:0] SEG_DIGIT_0 = 7'b1000000;
  localparam logic [6:0] SEG_DIGIT_1 = 7'b1111001;
  localparam logic [6:0] SEG_DIGIT_2 = 7'b0100100;
  localparam logic [6:0] SEG_DIGIT_3 = 7'b0110000;
  localparam logic [6:0] SEG_DIGIT_4 = 7'b0011001;
  localparam logic [6:0] SEG_DIGIT_5 = 7'b0010010;
  localparam logic [6:0] SEG_DIGIT_6 = 7'b0000010;
  localparam logic [6:0] SEG_DIGIT_7 = 7'b1111000;
  localparam logic [6:0] SEG_BLANK   = 7'b1111111;

  typedef struct packed {
    logic       is_digit;
    logic       is_blank;
    logic [2:0] digit;
  } seg_decode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_REJECT,
    ST_HOLD
  } state_t;

  // Forward mapping used by the transmit-side encoder.
  function automatic logic [6:0] octal_to_segments(input logic [2:0] digit);
    logic [6:0] pattern;
    case (digit)
      3'd0:    pattern = SEG_DIGIT_0;
      3'd1:    pattern = SEG_DIGIT_1;
      3'd2:    pattern = SEG_DIGIT_2;
      3'd3:    pattern = SEG_DIGIT_3;
      3'd4:    pattern = SEG_DIGIT_4;
      3'd5:    pattern = SEG_DIGIT_5;
      3'd6:    pattern = SEG_DIGIT_6;
      default: pattern = SEG_DIGIT_7;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seven_segment_pattern_lookup.sv
// Combinational classifier: 7-bit active-low segment pattern to digit / blank /
// invalid, with the octal value when it is a digit.
module seven_segment_pattern_lookup
  import seven_segment_to_octal_decoder_pkg::*;
(
  input  logic [6:0]  pattern,
  output seg_decode_t decode
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    decode.is_digit = 1'b1;
    decode.is_blank = 1'b0;
    decode.digit    = 3'd0;
    case (pattern)
      SEG_DIGIT_0: decode.digit = 3'd0;
      SEG_DIGIT_1: decode.digit = 3'd1;
      SEG_DIGIT_2: decode.digit = 3'd2;
      SEG_DIGIT_3: decode.digit = 3'd3;
      SEG_DIGIT_4: decode.digit = 3'd4;
      SEG_DIGIT_5: decode.digit = 3'd5;
      SEG_DIGIT_6: decode.digit = 3'd6;
      SEG_DIGIT_7: decode.digit = 3'd7;
      SEG_BLANK: begin
        decode.is_digit = 1'b0;
        decode.is_blank = 1'b1;
      end
      default: decode.is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_to_octal_decoder.sv
// Receive side of the display loopback: qualifies a stable segment pattern,
// decodes it to an octal digit and assembles digits into a multi-digit word.
module seven_segment_to_octal_decoder
  import seven_segment_to_octal_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 4
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic [6:0]                      segment_in,
  input  logic                            clear,
  output logic [2:0]                      octal_value,
  output logic                            octal_valid,
  output logic                            invalid_pattern,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
  output logic [3*NUM_DIGITS-1:0]         octal_word,
  output logic                            word_valid
);

  localparam int CNT_W  = $clog2(STABLE_CYCLES);
  localparam int DC_W   = $clog2(NUM_DIGITS + 1);
  localparam int WORD_W = 3 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [DC_W-1:0]  DIGITS_MAX = DC_W'(NUM_DIGITS);

  logic [6:0]       seg_q;
  logic [CNT_W-1:0] stable_cnt;
  seg_decode_t      decode;
  state_t           state;
  state_t           state_next;
  logic             seg_change;
  logic             qualified;
  logic             accept_go;
  logic             reject_go;
  logic             word_done;
  logic [WORD_W-1:0] word_shifted;

  seven_segment_pattern_lookup u_lookup (
    .pattern (seg_q),
    .decode  (decode)
  );

  assign seg_change = (segment_in != seg_q);
  // The pattern must still be present on the deciding edge, so a pattern seen
  // on only STABLE_CYCLES edges is treated as a glitch.
  assign qualified  = !seg_change && (stable_cnt == CNT_MAX);

  // Input sampler and stability counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      seg_q      <= SEG_BLANK;
      stable_cnt <= '0;
    end else begin
      seg_q <= segment_in;
      if (clear || seg_change) begin
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (qualified) begin
          if (decode.is_digit) begin
            state_next = ST_ACCEPT;
          end else if (!decode.is_blank) begin
            state_next = ST_REJECT;
          end
        end
      end
      // A pattern change landing on the one-cycle pulse state must not be
      // swallowed by HOLD, so it goes straight back to qualification.
      ST_ACCEPT, ST_REJECT: state_next = seg_change ? ST_IDLE : ST_HOLD;
      ST_HOLD:   if (seg_change) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (clear) begin
      state_next = ST_IDLE;
    end
  end

  // Output decode: pulses are registered on the edge that enters ACCEPT or
  // REJECT, so they are visible during that one-cycle state.
  always_comb begin
    accept_go = (state == ST_IDLE) && (state_next == ST_ACCEPT);
    reject_go = (state == ST_IDLE) && (state_next == ST_REJECT);
    word_done = (state == ST_ACCEPT) && (digit_count == DIGITS_MAX) && !clear;
  end

  if (NUM_DIGITS == 1) begin : g_single
    assign word_shifted = decode.digit;
  end else begin : g_multi
    assign word_shifted = {octal_word[WORD_W-4:0], decode.digit};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      octal_value     <= 3'd0;
      octal_valid     <= 1'b0;
      invalid_pattern <= 1'b0;
      word_valid      <= 1'b0;
      digit_count     <= '0;
      octal_word      <= '0;
    end else begin
      octal_valid     <= accept_go;
      invalid_pattern <= reject_go;
      word_valid      <= word_done;
      if (accept_go) begin
        octal_value <= decode.digit;
      end
      if (clear || reject_go || word_done) begin
        digit_count <= '0;
      end else if (accept_go) begin
        digit_count <= digit_count + DC_W'(1);
      end
      // A completed word stays readable until the next accepted digit.
      if (clear || reject_go) begin
        octal_word <= '0;
      end else if (accept_go) begin
        octal_word <= word_shifted;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_to_octal_decoder.sv
// Directed self-checking bench for the seven-segment to octal decoder.
module tb_seven_segment_to_octal_decoder;

  localparam int STABLE = 4;
  localparam logic [6:0] P_BLANK = 7'b1111111;
  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P_BAD = 7'b0000000;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [6:0]  segment_in = P_BLANK;
  logic        clear = 1'b0;
  logic [2:0]  octal_value;
  logic        octal_valid;
  logic        invalid_pattern;
  logic [2:0]  digit_count;
  logic [11:0] octal_word;
  logic        word_valid;

  int checks = 0;
  int failures = 0;
  int n_valid, n_word, n_invalid;

  seven_segment_to_octal_decoder #(.STABLE_CYCLES(STABLE), .NUM_DIGITS(4)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .segment_in      (segment_in),
    .clear           (clear),
    .octal_value     (octal_value),
    .octal_valid     (octal_valid),
    .invalid_pattern (invalid_pattern),
    .digit_count     (digit_count),
    .octal_word      (octal_word),
    .word_valid      (word_valid)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    resetn = 1'b0;
    clear = 1'b0;
    segment_in = P_BLANK;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    n_valid = 0;
    n_word = 0;
    n_invalid = 0;
  endtask

  // Drive a pattern for a number of edges, counting output pulses after each.
  task automatic hold(input logic [6:0] p, input int cycles);
    segment_in = p;
    repeat (cycles) begin
      @(posedge clock);
      #1;
      n_valid   += int'(octal_valid);
      n_word    += int'(word_valid);
      n_invalid += int'(invalid_pattern);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({octal_value, octal_valid, invalid_pattern, digit_count, octal_word, word_valid} !== '0) begin
      $display("FAIL reset_state: outputs=%h required all zero",
               {octal_value, octal_valid, invalid_pattern, digit_count, octal_word, word_valid});
      failures++;
    end
    hold(P1, 10); hold(P_BLANK, 10); hold(P2, 10);
    checks++;
    if (digit_count !== 3'd2) begin
      $display("FAIL reset_pre_count: digit_count=%0d required 2", digit_count);
      failures++;
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (octal_value !== 3'd0 || octal_word !== 12'd0 || digit_count !== 3'd0) begin
      $display("FAIL reset_async: value=%0d word=%o count=%0d required 0 0 0",
               octal_value, octal_word, digit_count);
      failures++;
    end
    @(posedge clock);
    #1 resetn = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (digit_count !== 3'd0 || octal_word !== 12'd0) begin
      $display("FAIL reset_release: count=%0d word=%o required 0 0", digit_count, octal_word);
      failures++;
    end
  endtask

  task automatic test_sequence();
    do_reset();
    hold(P3, 10); hold(P_BLANK, 10); hold(P7, 10); hold(P_BLANK, 10);
    hold(P0, 10); hold(P_BLANK, 10); hold(P5, 10);
    checks++;
    if (n_valid != 4) begin
      $display("FAIL seq_valid_count: got %0d required 4", n_valid);
      failures++;
    end
    checks++;
    if (n_word != 1) begin
      $display("FAIL seq_word_count: got %0d required 1", n_word);
      failures++;
    end
    checks++;
    if (octal_word !== 12'o3705) begin
      $display("FAIL seq_word: got %o required 3705", octal_word);
      failures++;
    end
    checks++;
    if (digit_count !== 3'd0 || octal_value !== 3'd5) begin
      $display("FAIL seq_tail: count=%0d value=%0d required 0 5", digit_count, octal_value);
      failures++;
    end
  endtask

  task automatic test_glitch_latency();
    do_reset();
    hold(P2, STABLE);
    hold(P_BLANK, 10);
    checks++;
    if (n_valid != 0) begin
      $display("FAIL glitch_no_pulse: pulses=%0d required 0", n_valid);
      failures++;
    end
    hold(P2, STABLE);
    checks++;
    if (n_valid != 0) begin
      $display("FAIL latency_early: pulses=%0d required 0 before edge %0d", n_valid, STABLE + 1);
      failures++;
    end
    @(posedge clock);
    #1;
    checks++;
    if (octal_valid !== 1'b1 || octal_value !== 3'd2) begin
      $display("FAIL latency_exact: valid=%b value=%0d required 1 2", octal_valid, octal_value);
      failures++;
    end
    hold(P2, 5);
    hold(P_BLANK, 10);
  endtask

  task automatic test_repeat_digit();
    do_reset();
    hold(P4, 50);
    hold(P4, 50);
    checks++;
    if (n_valid != 1) begin
      $display("FAIL repeat_no_blank: pulses=%0d required 1", n_valid);
      failures++;
    end
    hold(P_BLANK, 10);
    hold(P4, 10);
    checks++;
    if (n_valid != 2 || octal_word !== 12'o44) begin
      $display("FAIL repeat_with_blank: pulses=%0d word=%o required 2 44", n_valid, octal_word);
      failures++;
    end
  endtask

  task automatic test_invalid();
    do_reset();
    hold(P1, 10); hold(P_BLANK, 10); hold(P2, 10);
    hold(P_BAD, STABLE);
    @(posedge clock);
    #1;
    checks++;
    if (invalid_pattern !== 1'b1 || octal_valid !== 1'b0) begin
      $display("FAIL invalid_pulse: invalid=%b valid=%b required 1 0", invalid_pattern, octal_valid);
      failures++;
    end
    checks++;
    if (digit_count !== 3'd0 || octal_word !== 12'd0 || octal_value !== 3'd2) begin
      $display("FAIL invalid_flush: count=%0d word=%o value=%0d required 0 0 2",
               digit_count, octal_word, octal_value);
      failures++;
    end
    hold(P_BAD, 20);
    checks++;
    if (n_invalid != 0) begin
      $display("FAIL invalid_single: extra pulses=%0d required 0", n_invalid);
      failures++;
    end
    hold(P_BLANK, 10);
  endtask

  task automatic test_clear();
    do_reset();
    hold(P1, 10); hold(P_BLANK, 10); hold(P2, 10); hold(P_BLANK, 10);
    hold(P3, 10); hold(P_BLANK, 10);
    checks++;
    if (digit_count !== 3'd3 || octal_word !== 12'o123) begin
      $display("FAIL clear_pre: count=%0d word=%o required 3 123", digit_count, octal_word);
      failures++;
    end
    n_valid = 0;
    hold(P6, STABLE);
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    checks++;
    if (octal_valid !== 1'b0 || digit_count !== 3'd0 || octal_word !== 12'd0) begin
      $display("FAIL clear_accept: valid=%b count=%0d word=%o required 0 0 0",
               octal_valid, digit_count, octal_word);
      failures++;
    end
    checks++;
    if (octal_value !== 3'd3) begin
      $display("FAIL clear_keeps_value: value=%0d required 3", octal_value);
      failures++;
    end
    @(posedge clock);
    #1;
    checks++;
    if (word_valid !== 1'b0 || octal_valid !== 1'b0 || n_valid != 0) begin
      $display("FAIL clear_no_word: word_valid=%b valid=%b pulses=%0d required 0 0 0",
               word_valid, octal_valid, n_valid);
      failures++;
    end
    hold(P_BLANK, 10);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_glitch_latency();
    test_repeat_digit();
    test_invalid();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_segment_to_octal_decoder.md
# seven_segment_to_octal_decoder

Receive-side companion to the octal-to-seven-segment encoder: samples a 7-bit active-low segment bus, qualifies each pattern for stability, decodes it back to a 3-bit octal digit and assembles consecutive digits into a multi-digit octal word. It sits at the capture end of a display loopback path, so a bench or on-chip checker can confirm what the display drivers actually emitted.

## Interface
- STABLE_CYCLES, 4: consecutive matching samples needed to accept a pattern (≥2).
- NUM_DIGITS, 4: digits per assembled word (≥1).
- clock  input  1  system clock; all state on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- segment_in  input  7  segment pattern, bit 6 = g … bit 0 = a, active-low.
- clear  input  1  synchronous flush of FSM, counters and word.
- octal_value  output  3  last accepted digit; holds until next accept.
- octal_valid  output  1  one-cycle pulse per accepted digit.
- invalid_pattern  output  1  one-cycle pulse when a stable non-digit, non-blank pattern is qualified.
- digit_count  output  $clog2(NUM_DIGITS+1)  digits collected in current word.
- octal_word  output  3*NUM_DIGITS  assembled word, first digit in MS position.
- word_valid  output  1  one-cycle pulse when octal_word completes.

## Operation
- Digit patterns (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000. Blank = 1111111. Anything else is invalid.
- Input register seg_q captures segment_in every cycle. stable_cnt: cleared to 0 when segment_in ≠ seg_q, else increments, saturating at STABLE_CYCLES-1.
- FSM states:
  - IDLE: waiting for a new pattern. When stable_cnt reaches STABLE_CYCLES-1: blank → stay IDLE, no output; digit → ACCEPT; invalid → REJECT.
  - ACCEPT (one cycle): octal_valid=1, octal_value updated, digit shifted in: octal_word ← {octal_word[3*NUM_DIGITS-4:0], digit}; digit_count+1. Go to HOLD.
  - REJECT (one cycle): invalid_pattern=1, digit_count←0, octal_word←0. Go to HOLD.
  - HOLD: pattern already consumed; on segment_in ≠ seg_q, return to IDLE. Same digit repeated therefore requires an intervening different pattern (normally blank).
- Word completion: when the accept makes digit_count equal NUM_DIGITS, word_valid pulses the following cycle and digit_count returns to 0 on that same edge; octal_word holds its value until the next accept.
- clear: next edge forces IDLE, stable_cnt=0, digit_count=0, octal_word=0; pending pulses suppressed. clear wins over a simultaneous accept/reject. octal_value is not cleared.
- Width rule: digit_count never exceeds NUM_DIGITS; octal_word shifts, upper digit discarded only if NUM_DIGITS is exceeded (cannot occur by construction).

## Timing
- Reset values: octal_value=0, octal_valid=0, invalid_pattern=0, digit_count=0, octal_word=0, word_valid=0; FSM=IDLE, seg_q=7'b1111111, stable_cnt=0.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); partial word discarded.
- Latency: segment_in changes and holds before edge E0 → octal_valid (or invalid_pattern) high in the cycle after edge E0+STABLE_CYCLES (i.e. STABLE_CYCLES+1 edges after settle), from HOLD or IDLE.
- A glitch shorter than STABLE_CYCLES+1 cycles restarts qualification and produces no pulse.
- All outputs registered; no combinational path from segment_in to outputs.

## Structure
- Shared package: 7-bit pattern constants for digits 0–7 and BLANK, and the FSM state enum; the encoder and this decoder both reference the same constants.
- One natural sub-module: seven_segment_pattern_lookup (combinational pattern → {is_digit, is_blank, digit[2:0]}); FSM, stability counter and word assembler stay in the top.

## Test plan
- Reset: drive resetn low mid-word (digit_count=2) → all outputs zero asynchronously, digit_count=0 after release.
- Sequence 3,blank,7,blank,0,blank,5 each held 10 cycles, NUM_DIGITS=4 → four octal_valid pulses, word_valid once, octal_word=12'o3705.
- Pattern 2 held only STABLE_CYCLES cycles, then blank → no octal_valid; held STABLE_CYCLES+1 → octal_valid after exactly STABLE_CYCLES+1 edges.
- Digit 4 held 50 cycles then 4 again with no blank → single pulse; with blank between → two pulses.
- After two digits, stable 0000000 (invalid) → invalid_pattern pulse, digit_count=0, octal_word=0.
- clear asserted on the ACCEPT cycle of the fourth digit → no octal_valid/word_valid, digit_count=0, octal_word=0.
